// File: rtl/keypad_calc_pkg.sv
// Shared types and key codes for the keypad BCD calculator.
package keypad_calc_pkg;
  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_COMPARE = 3'd2,
    ST_CALC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_EQ    = 4'hD;
  localparam logic [3:0] BCD_BLANK = 4'hF;
endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single BCD digit adder/subtractor with carry/borrow.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;
  logic [4:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
    s    = 4'd0;
    cout = 1'b0;
    if (sub) begin
      // diff[4] is the borrow; adding 10 mod 16 restores the BCD digit
      if (diff[4]) begin
        s    = diff[3:0] + 4'd10;
        cout = 1'b1;
      end else begin
        s = diff[3:0];
      end
    end else begin
      if (sum > 5'd9) begin
        s    = 4'(sum - 5'd10);
        cout = 1'b1;
      end else begin
        s = sum[3:0];
      end
    end
  end
endmodule

// File: rtl/keypad_bcd_calc.sv
// Keypad-driven N-digit BCD add/subtract calculator with digit-serial datapath.
module keypad_bcd_calc
  import keypad_calc_pkg::*;
#(
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*N_DIGITS-1:0] disp_bcd,
  output logic                  neg,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic                  key_drop
);
  localparam int W  = 4 * N_DIGITS;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t        state;
  op_t           op;
  logic [W-1:0]  a, b, r;
  logic [IW-1:0] idx;
  logic          carry;
  logic [3:0]    s;
  logic          cout;

  // Operands shift right each CALC cycle so digit 0 is always the live digit
  bcd_digit_addsub u_digit (
    .a    (a[3:0]),
    .b    (b[3:0]),
    .cin  (carry),
    .sub  (op == OP_SUB),
    .s    (s),
    .cout (cout)
  );

  logic         is_digit, is_op, is_clr, is_eq, a_full, b_full, last;
  op_t          key_op;
  logic [W-1:0] a_shift, b_shift, r_next, key_word;

  always_comb begin
    is_digit = key_code <= 4'd9;
    is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    is_clr   = key_valid && (key_code == KEY_CLR);
    is_eq    = key_code == KEY_EQ;
    key_op   = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
    key_word = W'(key_code);
    a_full   = a[W-1 -: 4] != 4'd0;
    b_full   = b[W-1 -: 4] != 4'd0;
    a_shift  = (a << 4) | key_word;
    b_shift  = (b << 4) | key_word;
    r_next   = (r >> 4) | (W'(s) << (W - 4));
    last     = idx == IW'(N_DIGITS - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTER_A;
      op       <= OP_ADD;
      a        <= '0;
      b        <= '0;
      r        <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      disp_bcd <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      key_drop <= 1'b0;
    end else begin
      done     <= 1'b0;
      key_drop <= 1'b0;
      if (is_clr) begin
        a        <= '0;
        b        <= '0;
        r        <= '0;
        neg      <= 1'b0;
        overflow <= 1'b0;
        busy     <= 1'b0;
        disp_bcd <= '0;
        state    <= ST_ENTER_A;
      end else begin
        case (state)
          ST_ENTER_A: if (key_valid) begin
            if (is_digit) begin
              if (a_full) key_drop <= 1'b1;
              else begin
                a        <= a_shift;
                disp_bcd <= a_shift;
              end
            end else if (is_op) begin
              op       <= key_op;
              b        <= '0;
              disp_bcd <= '0;
              state    <= ST_ENTER_B;
            end
          end
          ST_ENTER_B: if (key_valid) begin
            if (is_digit) begin
              if (b_full) key_drop <= 1'b1;
              else begin
                b        <= b_shift;
                disp_bcd <= b_shift;
              end
            end else if (is_op) begin
              op <= key_op;
            end else if (is_eq) begin
              busy  <= 1'b1;
              state <= ST_COMPARE;
            end
          end
          ST_COMPARE: begin
            if (key_valid) key_drop <= 1'b1;
            if (op == OP_SUB && a < b) begin
              a   <= b;
              b   <= a;
              neg <= 1'b1;
            end else begin
              neg <= 1'b0;
            end
            idx   <= '0;
            carry <= 1'b0;
            state <= ST_CALC;
          end
          ST_CALC: begin
            if (key_valid) key_drop <= 1'b1;
            a     <= a >> 4;
            b     <= b >> 4;
            r     <= r_next;
            carry <= cout;
            idx   <= idx + IW'(1);
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
              if (op == OP_ADD && cout) begin
                overflow <= 1'b1;
                disp_bcd <= {N_DIGITS{BCD_BLANK}};
                state    <= ST_ERROR;
              end else begin
                disp_bcd <= r_next;
                state    <= ST_RESULT;
              end
            end
          end
          ST_RESULT: if (key_valid) begin
            if (is_digit) begin
              a        <= key_word;
              b        <= '0;
              neg      <= 1'b0;
              disp_bcd <= key_word;
              state    <= ST_ENTER_A;
            end else if (is_op) begin
              // A negative result cannot seed a chained operation
              if (neg) key_drop <= 1'b1;
              else begin
                a        <= r;
                b        <= '0;
                op       <= key_op;
                disp_bcd <= '0;
                state    <= ST_ENTER_B;
              end
            end
          end
          ST_ERROR: if (key_valid) key_drop <= 1'b1;
          default: state <= ST_ENTER_A;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_bcd_calc.sv
// Directed-vector bench for keypad_bcd_calc (N_DIGITS=3).
module tb_keypad_bcd_calc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [11:0] disp_bcd;
  logic        neg, overflow, busy, done, key_drop;
  int          tests_run = 0;
  int          tests_failed = 0;

  keypad_bcd_calc #(.N_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .disp_bcd(disp_bcd), .neg(neg), .overflow(overflow), .busy(busy),
    .done(done), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  // Returns at the negedge right after the key was sampled
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  // Called right after the equals press; cycle 1 is the first cycle after the strobe
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 1;
    busy_cycles = busy ? 1 : 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({disp_bcd, neg, overflow, busy, done, key_drop} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h exp 0", {disp_bcd, neg, overflow, busy, done, key_drop});
    end
  endtask

  task automatic test_add();
    int cyc, bc;
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5); press(4'h6);
    tests_run++;
    if (disp_bcd !== 12'h456) begin
      tests_failed++; $display("FAIL add_enter_b: got %h exp 456", disp_bcd);
    end
    press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5) begin tests_failed++; $display("FAIL add_latency: got %0d exp 5", cyc); end
    tests_run++;
    if (bc !== 4) begin tests_failed++; $display("FAIL add_busy_cycles: got %0d exp 4", bc); end
    tests_run++;
    if (disp_bcd !== 12'h579 || neg !== 1'b0) begin
      tests_failed++; $display("FAIL add_result: got %h neg %b exp 579 neg 0", disp_bcd, neg);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL add_done_pulse: got %b exp 0", done); end
  endtask

  task automatic test_overflow();
    int cyc, bc;
    press(4'hC);
    press(4'h9); press(4'h9); press(4'h9); press(4'hA); press(4'h1); press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || overflow !== 1'b1 || disp_bcd !== 12'hFFF) begin
      tests_failed++;
      $display("FAIL ovf_error: got cyc %0d ovf %b disp %h exp 5 1 fff", cyc, overflow, disp_bcd);
    end
    press(4'h5);
    tests_run++;
    if (key_drop !== 1'b1 || disp_bcd !== 12'hFFF) begin
      tests_failed++; $display("FAIL ovf_key_drop: got drop %b disp %h exp 1 fff", key_drop, disp_bcd);
    end
    press(4'hC);
    tests_run++;
    if (disp_bcd !== 12'h000 || overflow !== 1'b0 || key_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got disp %h ovf %b drop %b exp 000 0 0", disp_bcd, overflow, key_drop);
    end
  endtask

  task automatic test_sub();
    int cyc, bc;
    press(4'hC);
    press(4'h2); press(4'h5); press(4'hB); press(4'h1); press(4'h0); press(4'h0); press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || disp_bcd !== 12'h075 || neg !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_negative: got cyc %0d disp %h neg %b exp 5 075 1", cyc, disp_bcd, neg);
    end
    press(4'hA);
    tests_run++;
    if (key_drop !== 1'b1 || disp_bcd !== 12'h075) begin
      tests_failed++; $display("FAIL sub_neg_chain_drop: got drop %b disp %h exp 1 075", key_drop, disp_bcd);
    end
    press(4'h7);
    tests_run++;
    if (disp_bcd !== 12'h007 || neg !== 1'b0 || key_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_new_digit: got disp %h neg %b drop %b exp 007 0 0", disp_bcd, neg, key_drop);
    end
    press(4'hC);
    press(4'h5); press(4'hB); press(4'h5); press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (disp_bcd !== 12'h000 || neg !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL sub_self: got disp %h neg %b exp 000 0", disp_bcd, neg);
    end
  endtask

  task automatic test_entry_limits();
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3);
    tests_run++;
    if (key_drop !== 1'b0 || disp_bcd !== 12'h123) begin
      tests_failed++; $display("FAIL entry_third: got drop %b disp %h exp 0 123", key_drop, disp_bcd);
    end
    press(4'h4);
    tests_run++;
    if (key_drop !== 1'b1 || disp_bcd !== 12'h123) begin
      tests_failed++; $display("FAIL entry_full_drop: got drop %b disp %h exp 1 123", key_drop, disp_bcd);
    end
    press(4'hC);
    press(4'h0); press(4'h0);
    tests_run++;
    if (key_drop !== 1'b0 || disp_bcd !== 12'h000) begin
      tests_failed++; $display("FAIL entry_zeros: got drop %b disp %h exp 0 000", key_drop, disp_bcd);
    end
    press(4'hD);
    tests_run++;
    if (busy !== 1'b0 || key_drop !== 1'b0) begin
      tests_failed++; $display("FAIL entry_eq_in_a: got busy %b drop %b exp 0 0", busy, key_drop);
    end
  endtask

  task automatic test_busy_abort();
    int saw_done;
    press(4'hC);
    press(4'h5); press(4'hA); press(4'h3); press(4'hD);
    press(4'h7);
    tests_run++;
    if (key_drop !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL busy_drop: got drop %b busy %b exp 1 1", key_drop, busy);
    end
    press(4'hC);
    tests_run++;
    if (done !== 1'b0 || disp_bcd !== 12'h000 || busy !== 1'b0 || key_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_clear: got done %b disp %h busy %b drop %b exp 0 000 0 0", done, disp_bcd, busy, key_drop);
    end
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    tests_run++;
    if (saw_done !== 0) begin tests_failed++; $display("FAIL busy_no_done: got %0d exp 0", saw_done); end
  endtask

  task automatic test_chain_and_reset();
    int cyc, bc;
    press(4'hC);
    press(4'h8); press(4'hA); press(4'h4); press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (disp_bcd !== 12'h012 || neg !== 1'b0) begin
      tests_failed++; $display("FAIL chain_first: got %h neg %b exp 012 0", disp_bcd, neg);
    end
    press(4'hB);
    tests_run++;
    if (disp_bcd !== 12'h000 || key_drop !== 1'b0) begin
      tests_failed++; $display("FAIL chain_op: got disp %h drop %b exp 000 0", disp_bcd, key_drop);
    end
    press(4'h2); press(4'hD);
    wait_done(cyc, bc);
    tests_run++;
    if (cyc !== 5 || disp_bcd !== 12'h010 || neg !== 1'b0) begin
      tests_failed++; $display("FAIL chain_second: got cyc %0d %h neg %b exp 5 010 0", cyc, disp_bcd, neg);
    end
    press(4'h9); press(4'hA); press(4'h1); press(4'hD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({disp_bcd, neg, overflow, busy, done, key_drop} !== 17'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_calc: got %h exp 0", {disp_bcd, neg, overflow, busy, done, key_drop});
    end
    press(4'h3);
    tests_run++;
    if (disp_bcd !== 12'h003 || done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_enter_a: got disp %h done %b exp 003 0", disp_bcd, done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_entry_limits();
    test_busy_abort();
    test_chain_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
